// File: rtl/read_cache_pkg.sv
// rtl/read_cache_pkg.sv - shared types and default geometry for the read cache
package read_cache_pkg;

   localparam int ADDR_BITS_DEF = 8;
   localparam int DATA_BITS_DEF = 16;
   localparam int NUM_LINES_DEF = 16;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      MEM_READ   = 3'd1,
      READ_RESP  = 3'd2,
      MEM_WRITE  = 3'd3,
      WRITE_RESP = 3'd4
   } cache_state_t;

   // Tag width: whatever address bits remain above the line index.
   function automatic int tag_bits(int addr_bits, int num_lines);
      return addr_bits - $clog2(num_lines);
   endfunction

endpackage

// File: rtl/read_cache_if.sv
// rtl/read_cache_if.sv - 4-phase valid/ready read+write port (upstream and memory side)
interface read_cache_if
   import read_cache_pkg::*;
#(
   parameter int ADDR_BITS = ADDR_BITS_DEF,
   parameter int DATA_BITS = DATA_BITS_DEF
);
   logic                 read_valid;
   logic [ADDR_BITS-1:0] read_address;
   logic                 read_ready;
   logic [DATA_BITS-1:0] read_data;
   logic                 write_valid;
   logic [ADDR_BITS-1:0] write_address;
   logic [DATA_BITS-1:0] write_data;
   logic                 write_ready;

   modport master (
      output read_valid, read_address, write_valid, write_address, write_data,
      input  read_ready, read_data, write_ready
   );

   modport slave (
      input  read_valid, read_address, write_valid, write_address, write_data,
      output read_ready, read_data, write_ready
   );
endinterface

// File: rtl/read_cache_line_store.sv
// rtl/read_cache_line_store.sv - valid/tag/data arrays with combinational lookup and one write port
module read_cache_line_store
   import read_cache_pkg::*;
#(
   parameter int ADDR_BITS = ADDR_BITS_DEF,
   parameter int DATA_BITS = DATA_BITS_DEF,
   parameter int NUM_LINES = NUM_LINES_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear_all,
   input  logic [ADDR_BITS-1:0] lookup_addr,
   output logic                 hit,
   output logic [DATA_BITS-1:0] lookup_data,
   input  logic                 wr_en,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [DATA_BITS-1:0] wr_data
);
   localparam int IDX_BITS = $clog2(NUM_LINES);
   localparam int TAG_BITS = tag_bits(ADDR_BITS, NUM_LINES);

   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
   logic [TAG_BITS-1:0]  tag_d  [NUM_LINES];
   logic [DATA_BITS-1:0] data_q [NUM_LINES];
   logic [DATA_BITS-1:0] data_d [NUM_LINES];

   logic [IDX_BITS-1:0] lk_idx, wr_idx;
   logic [TAG_BITS-1:0] lk_tag, wr_tag;

   assign lk_idx      = lookup_addr[IDX_BITS-1:0];
   assign lk_tag      = lookup_addr[ADDR_BITS-1:IDX_BITS];
   assign wr_idx      = wr_addr[IDX_BITS-1:0];
   assign wr_tag      = wr_addr[ADDR_BITS-1:IDX_BITS];
   assign hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign lookup_data = data_q[lk_idx];

   // Next array contents: clear wipes only the valid bits; a write fills one whole line.
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (clear_all) begin
         valid_d = '0;
      end else if (wr_en) begin
         valid_d[wr_idx] = 1'b1;
         tag_d[wr_idx]   = wr_tag;
         data_d[wr_idx]  = wr_data;
      end
   end

   // Valid bits are the only state that must be known after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) valid_q <= '0;
      else       valid_q <= valid_d;
   end

   // Tag and data storage; contents are don't-care while the line is invalid.
   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end
endmodule

// File: rtl/read_cache.sv
// rtl/read_cache.sv - direct-mapped write-through read cache (optional CACHE_STATS_EN hit/miss counters)
module read_cache
   import read_cache_pkg::*;
#(
   parameter int ADDR_BITS = ADDR_BITS_DEF,
   parameter int DATA_BITS = DATA_BITS_DEF,
   parameter int NUM_LINES = NUM_LINES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   read_cache_if.slave up,
   read_cache_if.master mem,
   output logic        busy
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
`endif
);
   cache_state_t         state_q, state_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [DATA_BITS-1:0] wdata_q, wdata_d;
   logic [DATA_BITS-1:0] rdata_q, rdata_d;
   logic                 up_rd_rdy_q, up_rd_rdy_d;
   logic                 up_wr_rdy_q, up_wr_rdy_d;
   logic                 mem_rd_vld_q, mem_rd_vld_d;
   logic                 mem_wr_vld_q, mem_wr_vld_d;
`ifdef CACHE_STATS_EN
   logic [15:0]          hit_count_q, hit_count_d;
   logic [15:0]          miss_count_q, miss_count_d;
`endif

   logic                 clear_all, wr_en, hit;
   logic [ADDR_BITS-1:0] lookup_addr;
   logic [DATA_BITS-1:0] lookup_data, wr_data;

   // In IDLE the live request address is looked up; afterwards the latched one.
   assign lookup_addr = (state_q == IDLE) ? up.read_address : addr_q;

   read_cache_line_store #(
      .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .NUM_LINES(NUM_LINES)
   ) u_store (
      .clk(clk), .reset(reset), .clear_all(clear_all),
      .lookup_addr(lookup_addr), .hit(hit), .lookup_data(lookup_data),
      .wr_en(wr_en), .wr_addr(addr_q), .wr_data(wr_data)
   );

   // Controller: next state, latched request, registered handshakes and store commands.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      up_rd_rdy_d  = up_rd_rdy_q;
      up_wr_rdy_d  = up_wr_rdy_q;
      mem_rd_vld_d = mem_rd_vld_q;
      mem_wr_vld_d = mem_wr_vld_q;
      clear_all    = 1'b0;
      wr_en        = 1'b0;
      wr_data      = wdata_q;
`ifdef CACHE_STATS_EN
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (flush) begin
               clear_all = 1'b1;
`ifdef CACHE_STATS_EN
               hit_count_d  = '0;
               miss_count_d = '0;
`endif
            end else if (up.read_valid) begin
               if (hit) begin
                  rdata_d     = lookup_data;
                  up_rd_rdy_d = 1'b1;
                  state_d     = READ_RESP;
`ifdef CACHE_STATS_EN
                  if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
`endif
               end else if (!mem.read_ready) begin
                  // Wait for the previous memory response to retire before issuing.
                  addr_d       = up.read_address;
                  mem_rd_vld_d = 1'b1;
                  state_d      = MEM_READ;
`ifdef CACHE_STATS_EN
                  if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
`endif
               end
            end else if (up.write_valid && !mem.write_ready) begin
               addr_d       = up.write_address;
               wdata_d      = up.write_data;
               mem_wr_vld_d = 1'b1;
               state_d      = MEM_WRITE;
            end
         end
         MEM_READ: begin
            if (mem.read_ready) begin
               wr_en        = 1'b1;
               wr_data      = mem.read_data;
               rdata_d      = mem.read_data;
               mem_rd_vld_d = 1'b0;
               up_rd_rdy_d  = 1'b1;
               state_d      = READ_RESP;
            end
         end
         READ_RESP: begin
            if (!up.read_valid) begin
               up_rd_rdy_d = 1'b0;
               state_d     = IDLE;
            end
         end
         MEM_WRITE: begin
            if (mem.write_ready) begin
               // Write-through: refresh a resident line, never allocate on a miss.
               wr_en        = hit;
               mem_wr_vld_d = 1'b0;
               up_wr_rdy_d  = 1'b1;
               state_d      = WRITE_RESP;
            end
         end
         WRITE_RESP: begin
            if (!up.write_valid) begin
               up_wr_rdy_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset aborts any transaction and clears every output flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         up_rd_rdy_q  <= 1'b0;
         up_wr_rdy_q  <= 1'b0;
         mem_rd_vld_q <= 1'b0;
         mem_wr_vld_q <= 1'b0;
`ifdef CACHE_STATS_EN
         hit_count_q  <= '0;
         miss_count_q <= '0;
`endif
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         up_rd_rdy_q  <= up_rd_rdy_d;
         up_wr_rdy_q  <= up_wr_rdy_d;
         mem_rd_vld_q <= mem_rd_vld_d;
         mem_wr_vld_q <= mem_wr_vld_d;
`ifdef CACHE_STATS_EN
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
`endif
      end
   end

   assign up.read_ready       = up_rd_rdy_q;
   assign up.read_data        = rdata_q;
   assign up.write_ready      = up_wr_rdy_q;
   assign mem.read_valid      = mem_rd_vld_q;
   assign mem.read_address    = addr_q;
   assign mem.write_valid     = mem_wr_vld_q;
   assign mem.write_address   = addr_q;
   assign mem.write_data      = wdata_q;
   assign busy                = (state_q != IDLE);
`ifdef CACHE_STATS_EN
   assign hit_count           = hit_count_q;
   assign miss_count          = miss_count_q;
`endif
endmodule

// File: tb/tb_read_cache.sv
// tb/tb_read_cache.sv - directed table-driven bench for read_cache (CACHE_STATS_EN checks when defined)
module tb_read_cache;
   import read_cache_pkg::*;

   localparam int AB = 8;
   localparam int DB = 16;
   localparam int NL = 16;

   logic clk = 1'b0;
   logic reset;
   logic flush;
   logic busy;
`ifdef CACHE_STATS_EN
   logic [15:0] hit_count, miss_count;
`endif

   read_cache_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) up_if ();
   read_cache_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) mem_if ();

   read_cache #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_LINES(NL)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .up(up_if), .mem(mem_if), .busy(busy)
`ifdef CACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef enum logic [1:0] {OP_RD, OP_WR, OP_FL} op_t;
   typedef struct {
      op_t         op;
      logic [7:0]  addr;
      logic [15:0] data;
      logic        exp_miss;
      logic [15:0] exp_data;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Read transaction with a memory responder; called right after a negedge.
   task automatic do_read(input logic [7:0] addr, input logic [15:0] memdata,
                          output logic miss, output logic [15:0] data, output int lat);
      miss = 1'b0;
      lat  = 0;
      up_if.read_valid   = 1'b1;
      up_if.read_address = addr;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         lat++;
         if (up_if.read_ready) break;
         if (mem_if.read_valid && !mem_if.read_ready) begin
            miss = 1'b1;
            check("mem_rd_addr", 32'(mem_if.read_address), 32'(addr));
            mem_if.read_data  = memdata;
            mem_if.read_ready = 1'b1;
         end
      end
      check("rd_ready_seen", 32'(up_if.read_ready), 32'd1);
      data = up_if.read_data;
      if (miss) check("mem_rd_valid_drop", 32'(mem_if.read_valid), 32'd0);
      mem_if.read_ready = 1'b0;
      up_if.read_valid  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!up_if.read_ready && !busy) break;
      end
      check("rd_back_idle", 32'({up_if.read_ready, busy}), 32'd0);
   endtask

   // Write transaction; the up_* inputs are scrambled once latched to show they are ignored.
   task automatic do_write(input logic [7:0] addr, input logic [15:0] data);
      logic seen;
      seen = 1'b0;
      up_if.write_valid   = 1'b1;
      up_if.write_address = addr;
      up_if.write_data    = data;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (up_if.write_ready) break;
         if (mem_if.write_valid && !mem_if.write_ready) begin
            seen = 1'b1;
            check("mem_wr_addr", 32'(mem_if.write_address), 32'(addr));
            check("mem_wr_data", 32'(mem_if.write_data), 32'(data));
            up_if.write_address = ~addr;
            up_if.write_data    = ~data;
            mem_if.write_ready  = 1'b1;
         end
      end
      check("mem_wr_issued", 32'(seen), 32'd1);
      check("wr_ready_seen", 32'(up_if.write_ready), 32'd1);
      check("mem_wr_valid_drop", 32'(mem_if.write_valid), 32'd0);
      mem_if.write_ready = 1'b0;
      up_if.write_valid  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!up_if.write_ready && !busy) break;
      end
      check("wr_back_idle", 32'({up_if.write_ready, busy}), 32'd0);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(negedge clk);
      check("flush_not_busy", 32'(busy), 32'd0);
      flush = 1'b0;
      @(negedge clk);
   endtask

   // Read with expectation of hit/miss and data, plus 1-cycle latency on hits.
   task automatic exp_read(input string tag, input logic [7:0] addr, input logic [15:0] memdata,
                           input logic exp_miss, input logic [15:0] exp_data);
      logic miss;
      logic [15:0] data;
      int lat;
      do_read(addr, memdata, miss, data, lat);
      check({tag, "_miss"}, 32'(miss), 32'(exp_miss));
      check({tag, "_data"}, 32'(data), 32'(exp_data));
      if (!exp_miss) check({tag, "_hit_latency"}, 32'(lat), 32'd1);
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      up_if.read_valid = 1'b0;  up_if.read_address = '0;
      up_if.write_valid = 1'b0; up_if.write_address = '0; up_if.write_data = '0;
      mem_if.read_ready = 1'b0; mem_if.read_data = '0;
      mem_if.write_ready = 1'b0;

      vecs[0]  = '{OP_RD, 8'h12, 16'hBEEF, 1'b1, 16'hBEEF};
      vecs[1]  = '{OP_RD, 8'h12, 16'h0000, 1'b0, 16'hBEEF};
      vecs[2]  = '{OP_RD, 8'h22, 16'h2222, 1'b1, 16'h2222};
      vecs[3]  = '{OP_RD, 8'h12, 16'hBEEF, 1'b1, 16'hBEEF};
      vecs[4]  = '{OP_WR, 8'h12, 16'h1234, 1'b0, 16'h0000};
      vecs[5]  = '{OP_RD, 8'h12, 16'h0000, 1'b0, 16'h1234};
      vecs[6]  = '{OP_WR, 8'h40, 16'h4040, 1'b0, 16'h0000};
      vecs[7]  = '{OP_RD, 8'h40, 16'h4041, 1'b1, 16'h4041};
      vecs[8]  = '{OP_RD, 8'h40, 16'h0000, 1'b0, 16'h4041};
      vecs[9]  = '{OP_FL, 8'h00, 16'h0000, 1'b0, 16'h0000};
      vecs[10] = '{OP_RD, 8'h12, 16'h1234, 1'b1, 16'h1234};
      vecs[11] = '{OP_RD, 8'h12, 16'h0000, 1'b0, 16'h1234};
      vecs[12] = '{OP_WR, 8'h22, 16'h5555, 1'b0, 16'h0000};
      vecs[13] = '{OP_RD, 8'h12, 16'h0000, 1'b0, 16'h1234};
      vecs[14] = '{OP_RD, 8'hFF, 16'hAAAA, 1'b1, 16'hAAAA};
      vecs[15] = '{OP_RD, 8'hFF, 16'h0000, 1'b0, 16'hAAAA};

      repeat (2) @(negedge clk);
      check("rst_outputs", 32'({up_if.read_ready, up_if.write_ready, mem_if.read_valid,
                                mem_if.write_valid, busy}), 32'd0);
      check("rst_data", 32'({mem_if.read_address, up_if.read_data}), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 16; i++) begin
         case (vecs[i].op)
            OP_RD: exp_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data,
                            vecs[i].exp_miss, vecs[i].exp_data);
            OP_WR: do_write(vecs[i].addr, vecs[i].data);
            default: do_flush();
         endcase
      end

      // Flush held during MEM_READ is ignored; the miss completes normally.
      up_if.read_valid = 1'b1; up_if.read_address = 8'h33;
      @(negedge clk);
      check("fl_mem_rd_valid", 32'({mem_if.read_valid, busy}), 32'b11);
      flush = 1'b1;
      repeat (2) @(negedge clk);
      check("fl_still_pending", 32'({mem_if.read_valid, busy}), 32'b11);
      mem_if.read_data = 16'h3333; mem_if.read_ready = 1'b1;
      @(negedge clk);
      check("fl_rd_ready", 32'(up_if.read_ready), 32'd1);
      check("fl_rd_data", 32'(up_if.read_data), 32'h3333);
      flush = 1'b0; mem_if.read_ready = 1'b0; up_if.read_valid = 1'b0;
      @(negedge clk);
      check("fl_idle", 32'({up_if.read_ready, busy}), 32'd0);
      exp_read("fl_reread", 8'h33, 16'h0000, 1'b0, 16'h3333);

      // Read and write both pending in IDLE: the read goes first.
      up_if.read_valid = 1'b1;  up_if.read_address = 8'h44;
      up_if.write_valid = 1'b1; up_if.write_address = 8'h50; up_if.write_data = 16'h0A0A;
      @(negedge clk);
      check("rw_read_first", 32'({mem_if.read_valid, mem_if.write_valid}), 32'b10);
      check("rw_rd_addr", 32'(mem_if.read_address), 32'h44);
      mem_if.read_data = 16'h4444; mem_if.read_ready = 1'b1;
      @(negedge clk);
      check("rw_rd_done", 32'({up_if.read_ready, up_if.write_ready}), 32'b10);
      check("rw_rd_data", 32'(up_if.read_data), 32'h4444);
      mem_if.read_ready = 1'b0; up_if.read_valid = 1'b0;
      do_write(8'h50, 16'h0A0A);

      // Asynchronous reset in the middle of a memory read.
      up_if.read_valid = 1'b1; up_if.read_address = 8'h77;
      @(negedge clk);
      check("ar_pending", 32'(mem_if.read_valid), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("ar_outputs", 32'({mem_if.read_valid, up_if.read_ready, busy}), 32'd0);
      check("ar_addr", 32'(mem_if.read_address), 32'd0);
      up_if.read_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      exp_read("ar_cold", 8'h12, 16'h1234, 1'b1, 16'h1234);

      // Two hits and three misses since reset.
      exp_read("st_h1", 8'h12, 16'h0000, 1'b0, 16'h1234);
      exp_read("st_m2", 8'h55, 16'h5A5A, 1'b1, 16'h5A5A);
      exp_read("st_h2", 8'h55, 16'h0000, 1'b0, 16'h5A5A);
      exp_read("st_m3", 8'h66, 16'h6B6B, 1'b1, 16'h6B6B);
`ifdef CACHE_STATS_EN
      check("hit_count", 32'(hit_count), 32'd2);
      check("miss_count", 32'(miss_count), 32'd3);
      do_flush();
      check("cnt_flush_clear", 32'({hit_count, miss_count}), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
